// File: rtl/jtag_seq_pkg.sv
// Shared types and TAP preamble constants for the JTAG scan sequencer.
package jtag_seq_pkg;

   typedef enum logic [1:0] {
      CmdReset   = 2'd0,
      CmdShiftIr = 2'd1,
      CmdShiftDr = 2'd2,
      CmdIdle    = 2'd3
   } cmd_type_e;

   typedef enum logic [2:0] {
      StBridge,
      StAcquire,
      StTapRst,
      StReady,
      StRun,
      StResp,
      StRelease
   } seq_state_e;

   // TMS sequences are stored LSB first: bit 0 goes out on the first TCK.
   localparam int unsigned TAPRST_BITS  = 6;
   localparam logic [5:0]  TMS_RESET    = 6'b011111;
   localparam logic [2:0]  TMS_DR_ENTRY = 3'b001;
   localparam logic [3:0]  TMS_IR_ENTRY = 4'b0011;
   localparam logic [1:0]  TMS_EXIT     = 2'b01;

endpackage

// File: rtl/jtag_tck_gen.sv
// One-bit TCK generator: low phase then high phase of TCK_DIV clk cycles each.
module jtag_tck_gen #(
   parameter int unsigned TCK_DIV = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic req_i,
   input  logic tms_i,
   input  logic tdi_i,
   output logic accept_o,
   output logic tck_o,
   output logic tms_o,
   output logic tdi_o,
   output logic sample_o,
   output logic done_o
);

   localparam int unsigned CW = $clog2(2 * TCK_DIV);
   localparam logic [CW-1:0] CntHalf = CW'(TCK_DIV - 1);
   localparam logic [CW-1:0] CntLast = CW'(2 * TCK_DIV - 1);

   logic          active_q;
   logic [CW-1:0] cnt_q;
   logic          tck_q, tms_q, tdi_q;

   // Pulses: sample precedes the TCK rising edge, done marks the final high cycle.
   always_comb begin
      sample_o = active_q && (cnt_q == CntHalf);
      done_o   = active_q && (cnt_q == CntLast);
      accept_o = req_i && (!active_q || done_o);
      tck_o    = tck_q;
      tms_o    = tms_q;
      tdi_o    = tdi_q;
   end

   // Bit timing; a new request is taken back to back on the done cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         tck_q    <= 1'b0;
         tms_q    <= 1'b0;
         tdi_q    <= 1'b0;
      end else if (accept_o) begin
         active_q <= 1'b1;
         cnt_q    <= '0;
         tck_q    <= 1'b0;
         tms_q    <= tms_i;
         tdi_q    <= tdi_i;
      end else if (done_o) begin
         // Park TCK low between commands.
         active_q <= 1'b0;
         cnt_q    <= '0;
         tck_q    <= 1'b0;
         tdi_q    <= 1'b0;
      end else if (active_q) begin
         cnt_q <= cnt_q + CW'(1);
         if (cnt_q == CntHalf) tck_q <= 1'b1;
      end
   end

endmodule

// File: rtl/jtag_scan_sequencer.sv
// JTAG scan sequencer: borrows the TAP pins from the bit-bang bridge and runs scan commands.
module jtag_scan_sequencer
   import jtag_seq_pkg::*;
#(
   parameter int unsigned MAX_LEN     = 64,
   parameter int unsigned TCK_DIV     = 2,
   parameter int unsigned HOLD_CYCLES = 16,
   localparam int unsigned LW         = $clog2(MAX_LEN + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [1:0]         cmd_type_i,
   input  logic [LW-1:0]      cmd_len_i,
   input  logic [MAX_LEN-1:0] cmd_data_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [MAX_LEN-1:0] rsp_data_o,
   input  logic               bb_tms_i,
   input  logic               bb_tck_i,
   input  logic               bb_tdi_i,
   output logic               jtag_tms_o,
   output logic               jtag_tck_o,
   output logic               jtag_tdi_o,
   input  logic               jtag_tdo_i,
   output logic               seq_owns_o
);

   localparam int unsigned IW = $clog2(MAX_LEN + 7);
   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

   seq_state_e         state_q, state_d;
   logic [IW-1:0]      idx_q;
   logic [HW-1:0]      hold_q;
   cmd_type_e          cmd_type_q;
   logic [LW-1:0]      len_q;
   logic [MAX_LEN-1:0] data_q, rsp_data_q;

   cmd_type_e          run_type_c, new_type_c;
   logic [LW-1:0]      new_len_c;
   logic [IW-1:0]      total_c, new_total_c, cur_sidx_c;
   logic               cur_shift_c, nxt_tms_c, nxt_tdi_c, req_c, accept_c, hold_expired_c;
   logic               gen_accept, gen_tck, gen_tms, gen_tdi, gen_sample, gen_done;

   // Number of TCK bits in a command, from RTI back to RTI.
   function automatic logic [IW-1:0] bit_total(input cmd_type_e typ, input logic [LW-1:0] n);
      logic [IW-1:0] nn, res;
      nn = IW'(n);
      case (typ)
         CmdReset:   res = IW'(TAPRST_BITS);
         CmdIdle:    res = nn;
         CmdShiftDr: res = (nn == '0) ? '0 : nn + IW'(5);
         default:    res = (nn == '0) ? '0 : nn + IW'(6);
      endcase
      return res;
   endfunction

   // TMS/TDI for bit i of a command; returns {tms, tdi}.
   function automatic logic [1:0] bit_drive(input logic [IW-1:0] i, input cmd_type_e typ,
                                            input logic [LW-1:0] n,
                                            input logic [MAX_LEN-1:0] data);
      logic [IW-1:0]      pre, nn, j;
      logic [3:0]         entry;
      logic [MAX_LEN-1:0] sh;
      logic               tms, tdi;
      tms   = 1'b0;
      tdi   = 1'b0;
      nn    = IW'(n);
      pre   = (typ == CmdShiftIr) ? IW'(4) : IW'(3);
      entry = (typ == CmdShiftIr) ? TMS_IR_ENTRY : {1'b0, TMS_DR_ENTRY};
      j     = i - pre;
      sh    = data >> j;
      case (typ)
         CmdReset: if (i < IW'(TAPRST_BITS)) tms = TMS_RESET[i[2:0]];
         CmdIdle:  tms = 1'b0;
         default: begin
            if (i < pre) begin
               tms = entry[i[1:0]];
            end else if (j < nn) begin
               tms = (j == nn - IW'(1));
               tdi = sh[0];
            end else begin
               tms = (j == nn) ? TMS_EXIT[0] : TMS_EXIT[1];
            end
         end
      endcase
      return {tms, tdi};
   endfunction

   // Whether bit i is a shift bit and its position in the data word; returns {hit, pos}.
   function automatic logic [IW:0] shift_slot(input logic [IW-1:0] i, input cmd_type_e typ,
                                              input logic [LW-1:0] n);
      logic [IW-1:0] pre, j;
      logic          hit;
      pre = (typ == CmdShiftIr) ? IW'(4) : IW'(3);
      j   = i - pre;
      hit = (typ == CmdShiftIr || typ == CmdShiftDr) && (i >= pre) && (j < IW'(n));
      return {hit, j};
   endfunction

   // Command decode and the bit list position of the next and current TCK bits.
   always_comb begin
      run_type_c     = (state_q == StAcquire || state_q == StTapRst) ? CmdReset : cmd_type_q;
      new_type_c     = cmd_type_e'(cmd_type_i);
      new_len_c      = (cmd_len_i > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len_i;
      new_total_c    = bit_total(new_type_c, new_len_c);
      total_c        = bit_total(run_type_c, len_q);
      accept_c       = (state_q == StReady) && cmd_valid_i;
      hold_expired_c = (hold_q == HW'(HOLD_CYCLES - 1));
      req_c          = (state_q == StAcquire || state_q == StTapRst || state_q == StRun) &&
                       (idx_q < total_c);
      {nxt_tms_c, nxt_tdi_c}    = bit_drive(idx_q, run_type_c, len_q, data_q);
      // idx_q already points past the bit being clocked.
      {cur_shift_c, cur_sidx_c} = shift_slot(idx_q - IW'(1), run_type_c, len_q);
   end

   jtag_tck_gen #(
      .TCK_DIV (TCK_DIV)
   ) u_tck_gen (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (req_c),
      .tms_i    (nxt_tms_c),
      .tdi_i    (nxt_tdi_c),
      .accept_o (gen_accept),
      .tck_o    (gen_tck),
      .tms_o    (gen_tms),
      .tdi_o    (gen_tdi),
      .sample_o (gen_sample),
      .done_o   (gen_done)
   );

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= StBridge;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StBridge:  if (cmd_valid_i && !bb_tck_i) state_d = StAcquire;
         StAcquire: state_d = StTapRst;
         StTapRst:  if (gen_done && idx_q == total_c) state_d = StReady;
         StReady: begin
            // A command on the expiring cycle still wins over release.
            if (cmd_valid_i)         state_d = (new_total_c == '0) ? StResp : StRun;
            else if (hold_expired_c) state_d = StRelease;
         end
         StRun:     if (gen_done && idx_q == total_c) state_d = StResp;
         StResp:    if (rsp_ready_i) state_d = StReady;
         StRelease: state_d = StBridge;
         default:   state_d = StBridge;
      endcase
   end

   // Outputs and pin mux.
   always_comb begin
      cmd_ready_o = (state_q == StReady);
      rsp_valid_o = (state_q == StResp);
      seq_owns_o  = (state_q != StBridge);
      rsp_data_o  = rsp_data_q;
      jtag_tck_o  = (state_q != StBridge) ? gen_tck : bb_tck_i;
      jtag_tms_o  = (state_q != StBridge) ? gen_tms : bb_tms_i;
      jtag_tdi_o  = (state_q != StBridge) ? gen_tdi : bb_tdi_i;
   end

   // Bit index, hold timer, latched command and TDO capture.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q      <= '0;
         hold_q     <= '0;
         cmd_type_q <= CmdReset;
         len_q      <= '0;
         data_q     <= '0;
         rsp_data_q <= '0;
      end else begin
         if (state_q == StBridge || accept_c) idx_q <= '0;
         else if (gen_accept)                 idx_q <= idx_q + IW'(1);

         if (state_q == StReady && !cmd_valid_i) hold_q <= hold_q + HW'(1);
         else                                    hold_q <= '0;

         if (accept_c) begin
            cmd_type_q <= new_type_c;
            len_q      <= new_len_c;
            data_q     <= cmd_data_i;
            rsp_data_q <= '0;
         end else if (gen_sample && cur_shift_c) begin
            rsp_data_q <= rsp_data_q | ({{(MAX_LEN - 1){1'b0}}, jtag_tdo_i} << cur_sidx_c);
         end
      end
   end

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Directed bench for jtag_scan_sequencer with TCK_DIV=1, MAX_LEN=64, HOLD_CYCLES=16.
module tb_jtag_scan_sequencer;

   localparam int unsigned MaxLen = 64;
   localparam int unsigned Lw     = $clog2(MaxLen + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid, cmd_ready, rsp_valid, rsp_ready;
   logic [1:0]        cmd_type;
   logic [Lw-1:0]     cmd_len;
   logic [MaxLen-1:0] cmd_data, rsp_data;
   logic              bb_tms, bb_tck, bb_tdi;
   logic              jtag_tms, jtag_tck, jtag_tdi, jtag_tdo, seq_owns;
   logic              tdo_one;

   int                total = 0;
   int                bad = 0;
   int                rise_cnt = 0;
   logic [1023:0]     tms_log = '0;

   jtag_scan_sequencer #(
      .MAX_LEN     (MaxLen),
      .TCK_DIV     (1),
      .HOLD_CYCLES (16)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_type_i  (cmd_type),
      .cmd_len_i   (cmd_len),
      .cmd_data_i  (cmd_data),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data),
      .bb_tms_i    (bb_tms),
      .bb_tck_i    (bb_tck),
      .bb_tdi_i    (bb_tdi),
      .jtag_tms_o  (jtag_tms),
      .jtag_tck_o  (jtag_tck),
      .jtag_tdi_o  (jtag_tdi),
      .jtag_tdo_i  (jtag_tdo),
      .seq_owns_o  (seq_owns)
   );

   // TAP model: TDO echoes TDI, or is tied high.
   assign jtag_tdo = tdo_one ? 1'b1 : jtag_tdi;

   always #5 clk = ~clk;

   // Log TMS at every sequencer-driven TCK rise.
   always @(posedge jtag_tck) begin
      if (seq_owns) begin
         if (rise_cnt < 1024) tms_log[rise_cnt] = jtag_tms;
         rise_cnt = rise_cnt + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic collect(input int base, output int n, output logic [127:0] bits);
      bits = '0;
      n    = rise_cnt - base;
      for (int k = 0; k < n && k < 128; k++) bits[k] = tms_log[base + k];
   endtask

   // Issue one command and consume its response; lat counts cycles from accept to rsp_valid.
   task automatic do_cmd(input logic [1:0] typ, input logic [Lw-1:0] len,
                         input logic [MaxLen-1:0] data, output logic [MaxLen-1:0] rsp,
                         output int base, output int lat, output bit ok);
      int n;
      ok = 1'b1; rsp = '0; lat = 0; base = rise_cnt;
      cmd_type = typ; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 400) begin step(); n++; end
      if (!cmd_ready) begin
         total++; bad++; ok = 1'b0; cmd_valid = 1'b0;
         $display("FAIL cmd_accept: cmd_ready_o=%b, required 1 within 400 cycles", cmd_ready);
         return;
      end
      base = rise_cnt;
      step();
      cmd_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 400) begin step(); n++; end
      lat = n;
      if (!rsp_valid) begin
         total++; bad++; ok = 1'b0;
         $display("FAIL rsp_wait: rsp_valid_o=%b, required 1 within 400 cycles", rsp_valid);
         return;
      end
      rsp = rsp_data;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; cmd_type = 2'd0; cmd_len = '0; cmd_data = '0;
      rsp_ready = 1'b0; bb_tms = 1'b1; bb_tck = 1'b1; bb_tdi = 1'b0; tdo_one = 1'b0;
      repeat (3) step();
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
      total++; if (rsp_data !== '0) begin bad++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
      total++; if (seq_owns !== 1'b0) begin bad++; $display("FAIL rst_owns: got %b want 0", seq_owns); end
      total++; if (jtag_tck !== 1'b1 || jtag_tms !== 1'b1 || jtag_tdi !== 1'b0) begin
         bad++; $display("FAIL rst_pins: got tck/tms/tdi %b%b%b want 110", jtag_tck, jtag_tms, jtag_tdi);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_acquire();
      int base, n;
      logic [127:0] bits;
      bit early;
      cmd_type = 2'd3; cmd_len = '0; cmd_valid = 1'b1; bb_tck = 1'b1;
      early = 1'b0;
      repeat (5) begin step(); if (seq_owns !== 1'b0) early = 1'b1; end
      total++; if (early) begin bad++; $display("FAIL acq_wait_tck_low: owns went 1, want 0 while bb_tck=1"); end
      bb_tck = 1'b0;
      base = rise_cnt;
      step();
      total++; if (seq_owns !== 1'b1) begin bad++; $display("FAIL acq_owns: got %b want 1", seq_owns); end
      bb_tck = 1'b1;
      #1;
      total++; if (jtag_tck !== 1'b0) begin bad++; $display("FAIL acq_tck_low: got %b want 0", jtag_tck); end
      repeat (12) step();
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL acq_ready_early: got %b want 0", cmd_ready); end
      step();
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL acq_ready: got %b want 1", cmd_ready); end
      cmd_valid = 1'b0;
      collect(base, n, bits);
      total++; if (n !== 6) begin bad++; $display("FAIL acq_rises: got %0d want 6", n); end
      total++; if (bits !== 128'h1f) begin bad++; $display("FAIL acq_tms: got %h want 1f", bits); end
   endtask

   task automatic test_shift_dr();
      logic [MaxLen-1:0] rsp; logic [127:0] bits; int base, lat, n; bit ok;
      tdo_one = 1'b0;
      do_cmd(2'd2, Lw'(8), 64'hA5, rsp, base, lat, ok);
      collect(base, n, bits);
      total++; if (rsp !== 64'hA5) begin bad++; $display("FAIL dr_data: got %h want a5", rsp); end
      total++; if (n !== 13) begin bad++; $display("FAIL dr_rises: got %0d want 13", n); end
      total++; if (bits !== 128'hC01) begin bad++; $display("FAIL dr_tms: got %h want c01", bits); end
   endtask

   task automatic test_shift_ir();
      logic [MaxLen-1:0] rsp; logic [127:0] bits; int base, lat, n; bit ok;
      tdo_one = 1'b1;
      do_cmd(2'd1, Lw'(5), 64'h03, rsp, base, lat, ok);
      tdo_one = 1'b0;
      collect(base, n, bits);
      total++; if (rsp !== 64'h1F) begin bad++; $display("FAIL ir_data: got %h want 1f", rsp); end
      total++; if (n !== 11) begin bad++; $display("FAIL ir_rises: got %0d want 11", n); end
      total++; if (bits !== 128'h303) begin bad++; $display("FAIL ir_tms: got %h want 303", bits); end
   endtask

   task automatic test_clamp();
      logic [MaxLen-1:0] rsp; logic [127:0] bits, exp_bits; int base, lat, n; bit ok;
      exp_bits = '0; exp_bits[0] = 1'b1; exp_bits[66] = 1'b1; exp_bits[67] = 1'b1;
      do_cmd(2'd2, Lw'(70), 64'h0123_4567_89AB_CDEF, rsp, base, lat, ok);
      collect(base, n, bits);
      total++; if (rsp !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL clamp_data: got %h want 0123456789abcdef", rsp); end
      total++; if (n !== 69) begin bad++; $display("FAIL clamp_rises: got %0d want 69", n); end
      total++; if (bits !== exp_bits) begin bad++; $display("FAIL clamp_tms: got %h want %h", bits, exp_bits); end
   endtask

   task automatic test_idle_and_reset_cmd();
      logic [MaxLen-1:0] rsp; logic [127:0] bits; int base, lat, n; bit ok;
      do_cmd(2'd3, Lw'(0), '1, rsp, base, lat, ok);
      collect(base, n, bits);
      total++; if (lat !== 0) begin bad++; $display("FAIL idle0_latency: got %0d want 0", lat); end
      total++; if (n !== 0) begin bad++; $display("FAIL idle0_rises: got %0d want 0", n); end
      total++; if (rsp !== '0) begin bad++; $display("FAIL idle0_data: got %h want 0", rsp); end
      do_cmd(2'd3, Lw'(3), '1, rsp, base, lat, ok);
      collect(base, n, bits);
      total++; if (n !== 3) begin bad++; $display("FAIL idle3_rises: got %0d want 3", n); end
      total++; if (bits !== '0) begin bad++; $display("FAIL idle3_tms: got %h want 0", bits); end
      do_cmd(2'd0, Lw'(9), '1, rsp, base, lat, ok);
      collect(base, n, bits);
      total++; if (n !== 6) begin bad++; $display("FAIL rstcmd_rises: got %0d want 6", n); end
      total++; if (bits !== 128'h1f) begin bad++; $display("FAIL rstcmd_tms: got %h want 1f", bits); end
      total++; if (rsp !== '0) begin bad++; $display("FAIL rstcmd_data: got %h want 0", rsp); end
   endtask

   task automatic test_backpressure_release();
      int n; bit unstable;
      cmd_type = 2'd2; cmd_len = Lw'(4); cmd_data = 64'h9; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 100) begin step(); n++; end
      step();
      cmd_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 100) begin step(); n++; end
      unstable = 1'b0;
      repeat (10) begin
         if (rsp_valid !== 1'b1 || rsp_data !== 64'h9 || cmd_ready !== 1'b0) unstable = 1'b1;
         step();
      end
      total++; if (unstable) begin
         bad++; $display("FAIL bp_hold: got valid=%b data=%h ready=%b want 1/9/0", rsp_valid, rsp_data, cmd_ready);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after: got %b want 1", cmd_ready); end
      repeat (15) step();
      total++; if (seq_owns !== 1'b1) begin bad++; $display("FAIL hold_owns: got %b want 1", seq_owns); end
      repeat (2) step();
      total++; if (seq_owns !== 1'b0) begin bad++; $display("FAIL release_owns: got %b want 0", seq_owns); end
      bb_tck = 1'b1; #1;
      total++; if (jtag_tck !== 1'b1) begin bad++; $display("FAIL release_tck_hi: got %b want 1", jtag_tck); end
      bb_tck = 1'b0; #1;
      total++; if (jtag_tck !== 1'b0) begin bad++; $display("FAIL release_tck_lo: got %b want 0", jtag_tck); end
   endtask

   task automatic test_hold_race();
      logic [MaxLen-1:0] rsp; int base, lat; bit ok;
      do_cmd(2'd3, Lw'(0), '0, rsp, base, lat, ok);
      repeat (15) step();
      cmd_type = 2'd3; cmd_len = '0; cmd_valid = 1'b1;
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL race_ready: got %b want 1", cmd_ready); end
      step();
      cmd_valid = 1'b0;
      total++; if (rsp_valid !== 1'b1 || seq_owns !== 1'b1) begin
         bad++; $display("FAIL race_accept: got valid=%b owns=%b want 1/1", rsp_valid, seq_owns);
      end
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [MaxLen-1:0] rsp; logic [127:0] bits; int base, lat, n; bit ok;
      cmd_type = 2'd2; cmd_len = Lw'(8); cmd_data = 64'hFF; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 100) begin step(); n++; end
      base = rise_cnt;
      step();
      cmd_valid = 1'b0;
      n = 0;
      while (rise_cnt - base < 7 && n < 100) begin step(); n++; end
      step();
      bb_tck = 1'b1; bb_tms = 1'b1; bb_tdi = 1'b1;
      rst = 1'b1; #1;
      total++; if (seq_owns !== 1'b0 || rsp_valid !== 1'b0) begin
         bad++; $display("FAIL midrst_state: got owns=%b valid=%b want 0/0", seq_owns, rsp_valid);
      end
      total++; if ({jtag_tck, jtag_tms, jtag_tdi} !== 3'b111) begin
         bad++; $display("FAIL midrst_pins: got %b%b%b want 111", jtag_tck, jtag_tms, jtag_tdi);
      end
      step();
      rst = 1'b0; bb_tck = 1'b0; bb_tms = 1'b0; bb_tdi = 1'b0;
      base = rise_cnt;
      cmd_type = 2'd3; cmd_len = '0; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 100) begin step(); n++; end
      collect(base, n, bits);
      total++; if (n !== 6) begin bad++; $display("FAIL reacq_rises: got %0d want 6", n); end
      total++; if (bits !== 128'h1f) begin bad++; $display("FAIL reacq_tms: got %h want 1f", bits); end
      do_cmd(2'd3, Lw'(0), '0, rsp, base, lat, ok);
      total++; if (lat !== 0 || !ok) begin bad++; $display("FAIL reacq_cmd: got lat=%0d ok=%b want 0/1", lat, ok); end
   endtask

   initial begin
      test_reset();
      test_acquire();
      test_shift_dr();
      test_shift_ir();
      test_clamp();
      test_idle_and_reset_cmd();
      test_backpressure_release();
      test_hold_race();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, required bench completion");
      $fatal(1);
   end

endmodule
